// File: rtl/rom_dl_router.sv
// rom_dl_router: turns the linear HPS download stream into per-region ROM
// write strobes with region-local addresses. It tracks the byte count and an
// 8-bit checksum, and keeps the core in reset until a complete image has landed.
module rom_dl_router #(
   parameter logic [15:0] CPU_END  = 16'h7FFF,
   parameter logic [15:0] SND_END  = 16'h8FFF,
   parameter logic [15:0] GFX_END  = 16'hAFFF,
   parameter logic [16:0] IMG_SIZE = 17'hB020
) (
   input  logic        clk,
   input  logic        RESET,
   input  logic        dl_active,
   input  logic        dl_wr,
   input  logic [15:0] dl_addr,
   input  logic [7:0]  dl_data,
   output logic        cpu_we,
   output logic        snd_we,
   output logic        gfx_we,
   output logic        prom_we,
   output logic [15:0] rom_addr,
   output logic [7:0]  rom_data,
   output logic [16:0] byte_count,
   output logic [7:0]  checksum,
   output logic        rom_ready,
   output logic        core_reset
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_READY, S_FAIL} state_t;

   state_t      state;
   logic        dl_active_prev;
   logic        overflow;
   logic        rise;
   logic        fall;
   logic        accept;
   logic [3:0]  region;        // one-hot {prom, gfx, snd, cpu}
   logic [15:0] local_addr;
   logic        out_of_range;

   assign rise   = dl_active & ~dl_active_prev;
   assign fall   = ~dl_active & dl_active_prev;
   assign accept = dl_wr && (state == S_LOAD);

   // Decode the linear address into a region and its region-local offset.
   always_comb begin
      region       = 4'b0000;
      local_addr   = 16'h0000;
      out_of_range = 1'b0;
      if (dl_addr <= CPU_END) begin
         region     = 4'b0001;
         local_addr = dl_addr;
      end else if (dl_addr <= SND_END) begin
         region     = 4'b0010;
         local_addr = dl_addr - (CPU_END + 16'd1);
      end else if (dl_addr <= GFX_END) begin
         region     = 4'b0100;
         local_addr = dl_addr - (SND_END + 16'd1);
      end else if ({1'b0, dl_addr} < IMG_SIZE) begin
         region     = 4'b1000;
         local_addr = dl_addr - (GFX_END + 16'd1);
      end else begin
         out_of_range = 1'b1;
      end
   end

   // Download FSM with registered strobes, counters and core-reset control.
   // dl_active_prev resets high so that a download already in progress when
   // reset hits must drop and rise again before bytes are accepted.
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         state          <= S_IDLE;
         dl_active_prev <= 1'b1;
         overflow       <= 1'b0;
         cpu_we         <= 1'b0;
         snd_we         <= 1'b0;
         gfx_we         <= 1'b0;
         prom_we        <= 1'b0;
         rom_addr       <= 16'h0000;
         rom_data       <= 8'h00;
         byte_count     <= 17'h00000;
         checksum       <= 8'h00;
         rom_ready      <= 1'b0;
         core_reset     <= 1'b1;
      end else begin
         dl_active_prev <= dl_active;
         {prom_we, gfx_we, snd_we, cpu_we} <= 4'b0000;
         // Derived from the registered ready flag, so it trails the state by a cycle.
         core_reset     <= ~rom_ready | dl_active;
         case (state)
            S_IDLE, S_READY, S_FAIL: begin
               if (rise) begin
                  state      <= S_LOAD;
                  byte_count <= 17'h00000;
                  checksum   <= 8'h00;
                  overflow   <= 1'b0;
                  rom_ready  <= 1'b0;
               end
            end
            S_LOAD: begin
               // A byte arriving on the same edge dl_active falls is still taken.
               if (accept) begin
                  if (out_of_range) begin
                     overflow <= 1'b1;
                  end else begin
                     {prom_we, gfx_we, snd_we, cpu_we} <= region;
                     rom_addr <= local_addr;
                     rom_data <= dl_data;
                     if (byte_count != 17'h1FFFF)
                        byte_count <= byte_count + 17'd1;
                     checksum <= checksum + dl_data;
                  end
               end
               if (fall)
                  state <= S_CHECK;
            end
            S_CHECK: begin
               if ((byte_count == IMG_SIZE) && !overflow) begin
                  state     <= S_READY;
                  rom_ready <= 1'b1;
               end else begin
                  state <= S_FAIL;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rom_dl_router.sv
// tb_rom_dl_router: directed stimulus with a strobe scoreboard. The driver
// queues each expected ROM write; a negedge monitor pops and compares every
// strobe the router produces, including the cycle it should appear in.
module tb_rom_dl_router;

   logic        clk = 1'b0;
   logic        RESET = 1'b0;
   logic        dl_active, dl_wr;
   logic [15:0] dl_addr;
   logic [7:0]  dl_data;
   logic        cpu_we, snd_we, gfx_we, prom_we;
   logic [15:0] rom_addr;
   logic [7:0]  rom_data;
   logic [16:0] byte_count;
   logic [7:0]  checksum;
   logic        rom_ready, core_reset;

   typedef struct {
      logic [3:0]  we;
      logic [15:0] addr;
      logic [7:0]  data;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   rom_dl_router dut (
      .clk(clk), .RESET(RESET), .dl_active(dl_active), .dl_wr(dl_wr),
      .dl_addr(dl_addr), .dl_data(dl_data),
      .cpu_we(cpu_we), .snd_we(snd_we), .gfx_we(gfx_we), .prom_we(prom_we),
      .rom_addr(rom_addr), .rom_data(rom_data), .byte_count(byte_count),
      .checksum(checksum), .rom_ready(rom_ready), .core_reset(core_reset)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every strobe must match the oldest expected write.
   always @(negedge clk) begin
      if ({prom_we, gfx_we, snd_we, cpu_we} != 4'b0000) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_strobe: got we=%b addr=%h data=%h, expected no strobe",
                     {prom_we, gfx_we, snd_we, cpu_we}, rom_addr, rom_data);
         end else begin
            mon_e = exp_q.pop_front();
            check("strobe_we",   {28'h0, prom_we, gfx_we, snd_we, cpu_we}, {28'h0, mon_e.we});
            check("strobe_addr", {16'h0, rom_addr}, {16'h0, mon_e.addr});
            check("strobe_data", {24'h0, rom_data}, {24'h0, mon_e.data});
            check("strobe_cycle", cyc, mon_e.cyc);
         end
      end
   end

   // One download byte; ewe==0 means no strobe may result from it.
   task automatic drive(input logic [15:0] a, input logic [7:0] d,
                        input logic [3:0] ewe, input logic [15:0] ea);
      dl_wr   = 1'b1;
      dl_addr = a;
      dl_data = d;
      if (ewe != 4'b0000)
         exp_q.push_back('{we: ewe, addr: ea, data: d, cyc: cyc + 1});
      @(posedge clk); #1;
      dl_wr = 1'b0;
   endtask

   task automatic start_load();
      dl_active = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic stop_load();
      dl_active = 1'b0;
      @(posedge clk); #1;
   endtask

   // Whole image 0..B01F with data = addr[7:0]; optionally drop dl_active with the last byte.
   task automatic full_image(input bit drop_at_end);
      for (int a = 0; a < 'hB020; a++) begin
         logic [15:0] aa;
         logic [3:0]  w;
         logic [15:0] la;
         aa = a[15:0];
         if (aa <= 16'h7FFF)      begin w = 4'b0001; la = aa;            end
         else if (aa <= 16'h8FFF) begin w = 4'b0010; la = aa - 16'h8000; end
         else if (aa <= 16'hAFFF) begin w = 4'b0100; la = aa - 16'h9000; end
         else                     begin w = 4'b1000; la = aa - 16'hB000; end
         if (drop_at_end && a == 'hB01F)
            dl_active = 1'b0;
         drive(aa, aa[7:0], w, la);
      end
   endtask

   initial begin
      dl_active = 1'b0;
      dl_wr     = 1'b0;
      dl_addr   = 16'h0000;
      dl_data   = 8'h00;

      // Reset values
      #1 RESET = 1'b1;
      #1;
      check("rst_we",         {prom_we, gfx_we, snd_we, cpu_we}, 0);
      check("rst_rom_addr",   rom_addr, 0);
      check("rst_rom_data",   rom_data, 0);
      check("rst_byte_count", byte_count, 0);
      check("rst_checksum",   checksum, 0);
      check("rst_rom_ready",  rom_ready, 0);
      check("rst_core_reset", core_reset, 1);
      repeat (3) @(posedge clk);
      #1 RESET = 1'b0;
      repeat (2) @(posedge clk);
      #1 check("idle_core_reset", core_reset, 1);

      // Region edges
      start_load();
      drive(16'h7FFF, 8'h01, 4'b0001, 16'h7FFF);
      drive(16'h8000, 8'h02, 4'b0010, 16'h0000);
      drive(16'h8FFF, 8'h03, 4'b0010, 16'h0FFF);
      drive(16'h9000, 8'h04, 4'b0100, 16'h0000);
      drive(16'hAFFF, 8'h05, 4'b0100, 16'h1FFF);
      drive(16'hB000, 8'h06, 4'b1000, 16'h0000);
      drive(16'hB01F, 8'h07, 4'b1000, 16'h001F);
      check("edges_count",    byte_count, 7);
      check("edges_checksum", checksum, 8'h1C);
      stop_load();
      @(posedge clk); #1;
      check("edges_rom_ready", rom_ready, 0);
      @(posedge clk); #1;
      check("edges_core_reset", core_reset, 1);

      // Short image: 100 bytes, sum 0..99 = 4950 -> 0x56
      start_load();
      for (int i = 0; i < 100; i++)
         drive(i[15:0], i[7:0], 4'b0001, i[15:0]);
      stop_load();
      @(posedge clk); #1;
      check("short_count",     byte_count, 100);
      check("short_checksum",  checksum, 8'h56);
      check("short_rom_ready", rom_ready, 0);
      @(posedge clk); #1;
      check("short_core_reset", core_reset, 1);

      // Full image, dl_active falls with the final byte.
      // Checksum: 176 full 0..255 runs sum to 0 mod 256, plus 0..31 = 496 -> 0xF0.
      start_load();
      full_image(1'b1);
      check("full_count", byte_count, 17'hB020);
      @(posedge clk); #1;
      check("full_rom_ready",      rom_ready, 1);
      check("full_checksum",       checksum, 8'hF0);
      check("full_core_reset_lag", core_reset, 1);
      @(posedge clk); #1;
      check("full_core_reset", core_reset, 0);
      drive(16'h0010, 8'hAA, 4'b0000, 16'h0000);
      check("ready_ignore_count",    byte_count, 17'hB020);
      check("ready_ignore_checksum", checksum, 8'hF0);

      // Reload: rising dl_active drops ready and clears the counters
      dl_active = 1'b1;
      @(posedge clk); #1;
      check("reload_rom_ready",  rom_ready, 0);
      check("reload_count",      byte_count, 0);
      check("reload_checksum",   checksum, 0);
      @(posedge clk); #1;
      check("reload_core_reset", core_reset, 1);

      // Overflow: full image plus a byte at B020
      full_image(1'b0);
      drive(16'hB020, 8'h55, 4'b0000, 16'h0000);
      check("ovf_count", byte_count, 17'hB020);
      stop_load();
      @(posedge clk); #1;
      check("ovf_rom_ready", rom_ready, 0);
      @(posedge clk); #1;
      check("ovf_core_reset", core_reset, 1);
      check("ovf_rom_ready2", rom_ready, 0);

      // Async reset between clock edges during a load
      start_load();
      drive(16'h0040, 8'h10, 4'b0001, 16'h0040);
      drive(16'h0041, 8'h20, 4'b0001, 16'h0041);
      @(negedge clk); #1;
      RESET = 1'b1;
      #1;
      check("areset_we",         {prom_we, gfx_we, snd_we, cpu_we}, 0);
      check("areset_rom_addr",   rom_addr, 0);
      check("areset_rom_data",   rom_data, 0);
      check("areset_count",      byte_count, 0);
      check("areset_checksum",   checksum, 0);
      check("areset_rom_ready",  rom_ready, 0);
      check("areset_core_reset", core_reset, 1);
      #1 RESET = 1'b0;
      @(posedge clk); #1;
      drive(16'h0050, 8'h33, 4'b0000, 16'h0000);
      drive(16'h0051, 8'h34, 4'b0000, 16'h0000);
      check("areset_ignore_count", byte_count, 0);
      stop_load();
      start_load();
      drive(16'h0060, 8'h44, 4'b0001, 16'h0060);
      check("rearm_count",    byte_count, 1);
      check("rearm_checksum", checksum, 8'h44);

      repeat (2) @(posedge clk);
      #1;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
